parking_lot_ctrl: RTL and testbench
===================================

// Module: parking_lot_ctrl
// PURPOSE
//  Parametrised parking-lot controller: N_SLOTS bays, one entry sensor, one exit sensor per bay.
//  Synchronises and debounces all sensors, allocates the lowest free bay on entry and frees a bay on its exit.
//  Drives per-bay green/red LEDs, an entry gate and an occupancy count.
//  Top-level lot block; sensors come from the board, outputs go to LED and gate drivers.
// PARAMETERS
//  N_SLOTS          4    number of bays (1..16)
//  DEBOUNCE_CYCLES  4    consecutive stable synced samples needed to accept a level change (>=1)
//  GATE_CYCLES      8    cycles gate_open stays high after an allocation (>=1)
//  CNT_W            5    width of occupancy/reject counters; must hold N_SLOTS
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous, active-low reset
//  sense_entry    in   1        raw entry sensor, async, active-high
//  sense_exit     in   N_SLOTS  raw per-bay exit sensors, async, active-high; bit i = bay i
//  gled           out  N_SLOTS  bay i free
//  rled           out  N_SLOTS  bay i occupied; always ~gled
//  gate_open      out  1        entry gate open
//  assign_valid   out  1        1-cycle pulse: bay allocated
//  assign_slot    out  4        index of bay allocated; valid with assign_valid, holds value otherwise
//  reject         out  1        1-cycle pulse: entry refused, lot full
//  full           out  1        all bays occupied
//  occupancy      out  CNT_W    number of occupied bays
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: occ mask=0, gled=all 1, rled=0, gate_open=0, assign_valid=0, assign_slot=0, reject=0, full=0,
//   occupancy=0, FSM=IDLE, sync/debounce regs=0. Reset mid-operation aborts everything, including an open gate.
//  Input path, per sensor:
//   - 2-flop synchroniser.
//   - Debouncer: accepted level changes only after DEBOUNCE_CYCLES consecutive equal synced samples.
//   - Event = rising edge of the accepted level.
//   - Raw rise -> event: 2+DEBOUNCE_CYCLES cycles.
//   - Glitches shorter than DEBOUNCE_CYCLES produce no event.
//  FSM states: IDLE, GATE.
//   - IDLE + entry event + not full:
//     - Allocate the lowest-index free bay using the occ mask as registered before this edge.
//     - Next cycle: assign_valid=1, assign_slot=index, occ bit set, gate_open=1, go to GATE.
//   - IDLE + entry event + full: reject pulses 1 cycle; no other change; stay IDLE.
//   - GATE: gate_open held for GATE_CYCLES cycles, then gate_open=0 and return to IDLE.
//     Entry events during GATE are dropped (no reject, no count).
//  Exit event on bay i:
//   - Occupied: clear occ bit i next cycle.
//   - Not occupied: ignored.
//   - Multiple exit events in one cycle are all applied.
//  Exit and entry in the same cycle:
//   - The exit frees its bay.
//   - Allocation uses pre-edge occupancy, so a bay being freed is not reallocated that cycle.
//   - Lot full before the edge: reject, even if an exit occurs in that cycle.
//  Occupancy:
//   - Next-state popcount of the occ mask, registered with the mask.
//   - Never exceeds N_SLOTS; no wrap.
//  full = (occupancy == N_SLOTS), registered. gled = ~occ, rled = occ, both registered.
// CONFIGURATION
//  PARK_REJECT_CNT_EN defined:
//   - Adds output reject_count (CNT_W).
//   - Increments on every reject pulse; saturates at all-ones.
//   - Cleared only by reset.
//  Undefined: reject_count port and its logic absent; all other behaviour identical.
// TESTING
//  1. Reset released, no stimulus -> gled=4'b1111, rled=0, occupancy=0, full=0, gate_open=0.
//  2. Four separate entry pulses (each 20 cycles high, gaps > GATE_CYCLES):
//     -> assign_slot 0,1,2,3 in order; full=1 after the 4th; occupancy=4; rled=4'b1111.
//  3. Full lot + entry pulse -> reject 1-cycle pulse; occupancy stays 4; reject_count=1 when PARK_REJECT_CNT_EN.
//  4. sense_exit[1] pulse from full -> rled=4'b1101, full=0; next entry -> assign_slot=1.
//  5. Entry glitch 2 cycles wide (DEBOUNCE_CYCLES=4); exit on a free bay -> no assign_valid, no change.
//  6. Same-cycle entry and exit[0] with bays 0,1 occupied -> assign_slot=2; afterwards rled=4'b0110.
//     Separately, assert reset during GATE -> gate_open=0 immediately, all outputs return to reset values.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// ============================================================================
// Module   : parking_lot_ctrl
// Brief    : N-bay parking controller with synchronised, debounced sensors,
//            lowest-free-bay allocation, entry gate timer and occupancy count.
//            Optional PARK_REJECT_CNT_EN adds a saturating reject counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module parking_lot_ctrl #(
    parameter int N_SLOTS         = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 8,
    parameter int CNT_W           = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sense_entry,
    input  logic [N_SLOTS-1:0] sense_exit,
    output logic [N_SLOTS-1:0] gled,
    output logic [N_SLOTS-1:0] rled,
    output logic               gate_open,
    output logic               assign_valid,
    output logic [3:0]         assign_slot,
    output logic               reject,
    output logic               full,
`ifdef PARK_REJECT_CNT_EN
    output logic [CNT_W-1:0]   reject_count,
`endif
    output logic [CNT_W-1:0]   occupancy
);

    localparam int c_NSENS = N_SLOTS + 1;
    localparam int c_DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_GT_W  = $clog2(GATE_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_GATE = 1'b1;

    // Entry sensor occupies the top bit so exit bit i lines up with bay i.
    logic [c_NSENS-1:0] w_raw;
    logic [c_NSENS-1:0] r_sync1;
    logic [c_NSENS-1:0] r_sync2;
    logic [c_NSENS-1:0] w_lvl;
    logic [c_NSENS-1:0] r_lvl_d;
    logic [c_NSENS-1:0] w_ev;

    assign w_raw = {sense_entry, sense_exit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl_d <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_NSENS; gi++) begin : g_dbc
            logic [c_DB_W-1:0] r_cnt;
            logic              r_lvl;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b0;
                end else if (r_sync2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_lvl[gi] = r_lvl;
        end
    endgenerate

    assign w_ev = w_lvl & ~r_lvl_d;

    logic                 w_entry_ev;
    logic [N_SLOTS-1:0]   w_exit_ev;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [c_GT_W-1:0]    r_gate_cnt;
    logic [N_SLOTS-1:0]   r_occ;
    logic [N_SLOTS-1:0]   w_occ_nxt;
    logic [N_SLOTS-1:0]   w_free_oh;
    logic [3:0]           w_free_idx;
    logic [CNT_W-1:0]     w_pop;
    logic                 w_alloc;
    logic                 w_rej;
    logic                 w_gate_open;
    logic [N_SLOTS-1:0]   r_gled;
    logic [N_SLOTS-1:0]   r_rled;
    logic                 r_valid;
    logic [3:0]           r_slot;
    logic                 r_reject;
    logic                 r_full;
    logic [CNT_W-1:0]     r_occ_cnt;

    assign w_entry_ev = w_ev[N_SLOTS];
    assign w_exit_ev  = w_ev[N_SLOTS-1:0];

    // Entries are only honoured in IDLE; the full flag is the pre-edge one.
    assign w_alloc = (r_state == S_IDLE) && w_entry_ev && !r_full;
    assign w_rej   = (r_state == S_IDLE) && w_entry_ev &&  r_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_alloc) w_state_nxt = S_GATE;
            S_GATE: if (r_gate_cnt == c_GT_W'(GATE_CYCLES - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gate_open = (r_state == S_GATE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gate_cnt <= '0;
        end else if (r_state == S_GATE) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
        end else begin
            r_gate_cnt <= '0;
        end
    end

    // Descending scan so the lowest free index is the last one written.
    always_comb begin
        w_free_idx = 4'd0;
        w_free_oh  = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_idx   = 4'(i);
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
            end
        end
    end

    assign w_occ_nxt = (r_occ & ~w_exit_ev) | (w_alloc ? w_free_oh : '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_pop = w_pop + CNT_W'(w_occ_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ     <= '0;
            r_occ_cnt <= '0;
            r_full    <= 1'b0;
            r_gled    <= '1;
            r_rled    <= '0;
            r_valid   <= 1'b0;
            r_slot    <= 4'd0;
            r_reject  <= 1'b0;
        end else begin
            r_occ     <= w_occ_nxt;
            r_occ_cnt <= w_pop;
            r_full    <= (w_pop == CNT_W'(N_SLOTS));
            r_gled    <= ~w_occ_nxt;
            r_rled    <= w_occ_nxt;
            r_valid   <= w_alloc;
            r_reject  <= w_rej;
            if (w_alloc) begin
                r_slot <= w_free_idx;
            end
        end
    end

`ifdef PARK_REJECT_CNT_EN
    logic [CNT_W-1:0] r_rej_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rej_cnt <= '0;
        end else if (r_reject && (r_rej_cnt != {CNT_W{1'b1}})) begin
            r_rej_cnt <= r_rej_cnt + 1'b1;
        end
    end

    assign reject_count = r_rej_cnt;
`endif

    assign gled         = r_gled;
    assign rled         = r_rled;
    assign gate_open    = w_gate_open;
    assign assign_valid = r_valid;
    assign assign_slot  = r_slot;
    assign reject       = r_reject;
    assign full         = r_full;
    assign occupancy    = r_occ_cnt;

endmodule

`default_nettype wire

// File: tb/tb_parking_lot_ctrl.sv
// ============================================================================
// Module   : tb_parking_lot_ctrl
// Brief    : Directed self-checking bench for parking_lot_ctrl (default params).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_parking_lot_ctrl;

    logic       clk;
    logic       reset;
    logic       sense_entry;
    logic [3:0] sense_exit;
    logic [3:0] gled;
    logic [3:0] rled;
    logic       gate_open;
    logic       assign_valid;
    logic [3:0] assign_slot;
    logic       reject;
    logic       full;
    logic [4:0] occupancy;
`ifdef PARK_REJECT_CNT_EN
    logic [4:0] reject_count;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int n_valid = 0;
    int n_rej   = 0;
    logic [3:0] last_slot = 4'd0;

    parking_lot_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .sense_entry  (sense_entry),
        .sense_exit   (sense_exit),
        .gled         (gled),
        .rled         (rled),
        .gate_open    (gate_open),
        .assign_valid (assign_valid),
        .assign_slot  (assign_slot),
        .reject       (reject),
        .full         (full),
`ifdef PARK_REJECT_CNT_EN
        .reject_count (reject_count),
`endif
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles so a stretched pulse is also caught.
    always @(negedge clk) begin
        if (reset && assign_valid) begin
            n_valid++;
            last_slot = assign_slot;
        end
        if (reset && reject) n_rej++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic pulse_entry(input int hi);
        @(negedge clk) sense_entry = 1'b1;
        repeat (hi) @(negedge clk);
        sense_entry = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    task automatic pulse_exit(input int idx);
        @(negedge clk) sense_exit[idx] = 1'b1;
        repeat (20) @(negedge clk);
        sense_exit[idx] = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        int v0;
        int r0;
        reset       = 1'b0;
        sense_entry = 1'b0;
        sense_exit  = 4'b0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Idle after reset
        chk("rst_gled", 32'(gled), 32'hF);
        chk("rst_rled", 32'(rled), 32'h0);
        chk("rst_occ",  32'(occupancy), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_gate", 32'(gate_open), 32'd0);

        // Fill the lot in order
        for (int k = 0; k < 4; k++) begin
            v0 = n_valid;
            pulse_entry(20);
            chk("fill_valid", 32'(n_valid), 32'(v0 + 1));
            chk("fill_slot",  32'(last_slot), 32'(k));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_occ",  32'(occupancy), 32'd4);
        chk("fill_rled", 32'(rled), 32'hF);
        chk("fill_gled", 32'(gled), 32'h0);

        // Entry on a full lot
        v0 = n_valid;
        pulse_entry(20);
        chk("rej_pulse", 32'(n_rej), 32'd1);
        chk("rej_occ",   32'(occupancy), 32'd4);
        chk("rej_noval", 32'(n_valid), 32'(v0));
`ifdef PARK_REJECT_CNT_EN
        chk("rej_count", 32'(reject_count), 32'd1);
`endif

        // Free bay 1 then refill it
        pulse_exit(1);
        chk("ex1_rled", 32'(rled), 32'hD);
        chk("ex1_full", 32'(full), 32'd0);
        chk("ex1_occ",  32'(occupancy), 32'd3);
        pulse_entry(20);
        chk("re1_slot", 32'(last_slot), 32'd1);
        chk("re1_full", 32'(full), 32'd1);

        // Free bay 3, then exit on it again and glitch the entry sensor
        pulse_exit(3);
        chk("ex3_rled", 32'(rled), 32'h7);
        v0 = n_valid;
        r0 = n_rej;
        pulse_exit(3);
        chk("ex3b_rled", 32'(rled), 32'h7);
        chk("ex3b_occ",  32'(occupancy), 32'd3);
        pulse_entry(2);
        chk("glitch_val", 32'(n_valid), 32'(v0));
        chk("glitch_rej", 32'(n_rej), 32'(r0));
        chk("glitch_occ", 32'(occupancy), 32'd3);

        // Leave bays 0,1 occupied, then same-cycle entry and exit[0]
        pulse_exit(2);
        chk("ex2_rled", 32'(rled), 32'h3);
        @(negedge clk);
        sense_entry   = 1'b1;
        sense_exit[0] = 1'b1;
        repeat (20) @(negedge clk);
        sense_entry   = 1'b0;
        sense_exit[0] = 1'b0;
        repeat (25) @(negedge clk);
        chk("same_slot", 32'(last_slot), 32'd2);
        chk("same_rled", 32'(rled), 32'h6);
        chk("same_occ",  32'(occupancy), 32'd2);

        // Reset while the gate is open
        @(negedge clk) sense_entry = 1'b1;
        for (int k = 0; k < 40 && !gate_open; k++) @(negedge clk);
        chk("gate_seen", 32'(gate_open), 32'd1);
        chk("gate_slot", 32'(assign_slot), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("arst_gate", 32'(gate_open), 32'd0);
        chk("arst_gled", 32'(gled), 32'hF);
        chk("arst_rled", 32'(rled), 32'h0);
        chk("arst_occ",  32'(occupancy), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_slot", 32'(assign_slot), 32'd0);
        sense_entry = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_gate", 32'(gate_open), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
